// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU results with extended load data held in a small FIFO.
// The ALU path has strict priority, and a query port reports registers that still have a write pending.
module wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu_valid,
  input  logic [4:0]    alu_rd,
  input  logic [31:0]   alu_data,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [4:0]    ld_rd,
  input  logic [2:0]    ld_funct3,
  input  logic [1:0]    ld_off,
  input  logic [31:0]   ld_word,
  output logic          we3,
  output logic [4:0]    wa3,
  output logic [31:0]   wd3,
  input  logic [4:0]    q_rs1,
  input  logic [4:0]    q_rs2,
  input  logic [4:0]    q_rd,
  output logic          q_hazard,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [31:0]      fifo_data [DEPTH];
  logic [4:0]       fifo_rd   [DEPTH];
  logic [DEPTH-1:0] fifo_valid;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push;
  logic             pop;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [31:0]      ld_value;

  // Readiness depends only on registered occupancy, so a same-cycle pop never opens a slot.
  assign ld_ready = !rst && (count < CW'(DEPTH));
  assign push     = ld_valid && ld_ready;
  assign pop      = !alu_valid && (count != '0);

  always_comb begin
    ld_byte = 8'(ld_word >> {ld_off, 3'b000});
    ld_half = ld_off[1] ? ld_word[31:16] : ld_word[15:0];
    case (ld_funct3)
      3'b000:  ld_value = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_value = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_value = {24'b0, ld_byte};
      3'b101:  ld_value = {16'b0, ld_half};
      default: ld_value = ld_word;
    endcase
  end

  // Payload storage needs no reset; the valid bits decide what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= ld_value;
      fifo_rd[wr_ptr]   <= ld_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we3        <= 1'b0;
      wa3        <= '0;
      wd3        <= '0;
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_valid <= '0;
    end else begin
      if (alu_valid) begin
        wa3 <= alu_rd;
        wd3 <= alu_data;
        we3 <= (alu_rd != 5'd0);
      end else if (pop) begin
        wa3                <= fifo_rd[rd_ptr];
        wd3                <= fifo_data[rd_ptr];
        we3                <= (fifo_rd[rd_ptr] != 5'd0);
        fifo_valid[rd_ptr] <= 1'b0;
        rd_ptr             <= rd_ptr + PW'(1);
      end else begin
        we3 <= 1'b0;
      end

      // Push and pop never target the same slot: pop needs count>0, push needs count<DEPTH.
      if (push) begin
        fifo_valid[wr_ptr] <= 1'b1;
        wr_ptr             <= wr_ptr + PW'(1);
      end

      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (!push && pop) begin
        count <= count - CW'(1);
      end
    end
  end

  function automatic logic reg_match(input logic [4:0] r, input logic [4:0] q);
    return (q != 5'd0) && (r == q);
  endfunction

  // The output register counts as pending because the register file has not yet absorbed it.
  always_comb begin
    q_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (fifo_valid[i] && (reg_match(fifo_rd[i], q_rs1) || reg_match(fifo_rd[i], q_rs2) ||
                            reg_match(fifo_rd[i], q_rd))) begin
        q_hazard = 1'b1;
      end
    end
    if (we3 && (reg_match(wa3, q_rs1) || reg_match(wa3, q_rs2) || reg_match(wa3, q_rd))) begin
      q_hazard = 1'b1;
    end
  end

endmodule
